// File: rtl/bridge_link_pkg.sv
// rtl/bridge_link_pkg.sv - shared types, constants and frame layout for bridge_uart_link
package bridge_link_pkg;

    localparam int REQ_W = 25;
    localparam int FRAME_BYTES = 4;
    localparam logic [3:0] HDR_NIBBLE = 4'hA;

    typedef enum logic [1:0] {IDLE, TX_LOAD, TX_SHIFT, AWAIT_RSP} state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Byte k of the outgoing frame, MSB byte first; byte0 carries the header and mode bit.
    function automatic logic [7:0] frame_byte(input logic [REQ_W-1:0] req, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = {HDR_NIBBLE, 3'b000, req[24]};
            2'd1:    b = req[23:16];
            2'd2:    b = req[15:8];
            default: b = req[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 receiver: synchronizer, start qualification, mid-bit sampling
module uart_rx_core
    import bridge_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err_pulse
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    rx_state_t state, next_state;
    logic rx_s1, rx_s2, rx_s3;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] shift;
    logic fall, sample;

    assign fall = rx_s3 & ~rx_s2;

    always_ff @(posedge clk) begin
        if (rst) state <= RX_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            RX_IDLE:  if (fall) next_state = RX_START;
            // A start bit that is high again at half a bit-time was a glitch.
            RX_START: if (cnt == HALF_LAST) next_state = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt == FULL_LAST && bit_idx == 3'd7) next_state = RX_STOP;
            RX_STOP:  if (cnt == FULL_LAST) next_state = RX_IDLE;
            default:  next_state = RX_IDLE;
        endcase
    end

    always_comb begin
        sample = 1'b0;
        case (state)
            RX_START:         sample = (cnt == HALF_LAST);
            RX_DATA, RX_STOP: sample = (cnt == FULL_LAST);
            default:          sample = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1           <= 1'b1;
            rx_s2           <= 1'b1;
            rx_s3           <= 1'b1;
            cnt             <= '0;
            bit_idx         <= '0;
            shift           <= '0;
            data            <= '0;
            data_valid      <= 1'b0;
            frame_err_pulse <= 1'b0;
        end else begin
            rx_s1           <= rx;
            rx_s2           <= rx_s1;
            rx_s3           <= rx_s2;
            data_valid      <= 1'b0;
            frame_err_pulse <= 1'b0;
            if (state == RX_IDLE || sample) cnt <= '0;
            else                            cnt <= cnt + 1'b1;
            if (state == RX_START) bit_idx <= '0;
            if (sample && state == RX_DATA) begin
                shift   <= {rx_s2, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (sample && state == RX_STOP) begin
                if (rx_s2) begin
                    data       <= shift;
                    data_valid <= 1'b1;
                end else begin
                    frame_err_pulse <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bridge_uart_link.sv
// rtl/bridge_uart_link.sv - serializes bridge requests as 4-byte 8N1 frames and collects read responses
module bridge_uart_link
    import bridge_link_pkg::*;
#(
    parameter int         CLKS_PER_BIT     = 434,
    parameter int         RSP_TIMEOUT_BITS = 64,
    parameter logic [7:0] TIMEOUT_DATA     = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REQ_W-1:0] req_data,
    input  logic             req_valid,
    output logic [7:0]       rsp_data,
    output logic             rsp_valid,
    output logic             uart_tx,
    input  logic             uart_rx,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err,
    output logic             timeout
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int TO_W   = $clog2(RSP_TIMEOUT_BITS + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_EARLY = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(RSP_TIMEOUT_BITS - 1);

    state_t state, next_state;
    logic req_valid_q;
    logic [REQ_W-1:0] req_q;
    logic [9:0] shifter;
    logic [BAUD_W-1:0] baud_cnt;
    logic [3:0] bit_cnt;
    logic [1:0] byte_idx;
    logic [TO_W-1:0] to_cnt;
    logic [7:0] rx_data;
    logic rx_valid, rx_ferr;
    logic req_edge, baud_wrap, last_byte, byte_done, to_expire;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk             (clk),
        .rst             (rst),
        .rx              (uart_rx),
        .data            (rx_data),
        .data_valid      (rx_valid),
        .frame_err_pulse (rx_ferr)
    );

    assign req_edge  = req_valid & ~req_valid_q;
    assign baud_wrap = (baud_cnt == BAUD_LAST);
    assign last_byte = (byte_idx == 2'(FRAME_BYTES - 1));
    // uart_tx lags the shifter by one cycle: inner bytes hand over a cycle early so the
    // TX_LOAD cycle is the tail of the stop bit; the last byte waits for the line to finish.
    assign byte_done = last_byte ? (bit_cnt == 4'd10)
                                 : (bit_cnt == 4'd9 && baud_cnt == BAUD_EARLY);
    assign to_expire = baud_wrap && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (req_edge) next_state = TX_LOAD;
            TX_LOAD:   next_state = TX_SHIFT;
            TX_SHIFT:  if (byte_done) begin
                           if (!last_byte)    next_state = TX_LOAD;
                           else if (req_q[24]) next_state = IDLE;
                           else               next_state = AWAIT_RSP;
                       end
            AWAIT_RSP: if (rx_valid || to_expire) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid_q <= 1'b0;
            req_q       <= '0;
            shifter     <= '1;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            byte_idx    <= '0;
            to_cnt      <= '0;
            uart_tx     <= 1'b1;
            rsp_data    <= '0;
            rsp_valid   <= 1'b0;
            timeout     <= 1'b0;
            overrun     <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            req_valid_q <= req_valid;
            uart_tx     <= shifter[0];
            rsp_valid   <= 1'b0;
            timeout     <= 1'b0;
            if (rx_ferr) frame_err <= 1'b1;
            if (req_edge && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    shifter  <= '1;
                    byte_idx <= '0;
                    if (req_edge) req_q <= req_data;
                end
                TX_LOAD: begin
                    shifter  <= {1'b1, frame_byte(req_q, byte_idx), 1'b0};
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
                TX_SHIFT: begin
                    baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
                    if (baud_wrap) begin
                        shifter <= {1'b1, shifter[9:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    if (byte_done) begin
                        byte_idx <= byte_idx + 2'd1;
                        baud_cnt <= '0;
                        to_cnt   <= '0;
                    end
                end
                AWAIT_RSP: begin
                    baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
                    if (baud_wrap) to_cnt <= to_cnt + 1'b1;
                    if (rx_valid) begin
                        rsp_data  <= rx_data;
                        rsp_valid <= 1'b1;
                    end else if (to_expire) begin
                        rsp_data  <= TIMEOUT_DATA;
                        rsp_valid <= 1'b1;
                        timeout   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bridge_uart_link.sv
// tb/tb_bridge_uart_link.sv - scoreboard bench for bridge_uart_link
module tb_bridge_uart_link;
    localparam int CPB = 4;
    localparam int TOB = 16;
    localparam int LIMIT = 2000;

    typedef struct packed {
        logic [7:0] data;
        logic       to;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [24:0] req_data;
    logic        req_valid;
    logic [7:0]  rsp_data;
    logic        rsp_valid;
    logic        uart_tx;
    logic        uart_rx;
    logic        busy, overrun, frame_err, timeout;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_tx[$];
    rsp_t exp_rsp[$];

    bridge_uart_link #(.CLKS_PER_BIT(CPB), .RSP_TIMEOUT_BITS(TOB), .TIMEOUT_DATA(8'hFF)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_data  (req_data),
        .req_valid (req_valid),
        .rsp_data  (rsp_data),
        .rsp_valid (rsp_valid),
        .uart_tx   (uart_tx),
        .uart_rx   (uart_rx),
        .busy      (busy),
        .overrun   (overrun),
        .frame_err (frame_err),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [24:0] d);
        exp_tx.push_back({4'hA, 3'b000, d[24]});
        exp_tx.push_back(d[23:16]);
        exp_tx.push_back(d[15:8]);
        exp_tx.push_back(d[7:0]);
    endtask

    task automatic pulse_req(input logic [24:0] d);
        @(posedge clk); #1;
        req_data = d;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
    endtask

    // Cycles from the capturing edge until busy is seen low.
    task automatic wait_idle(output int k);
        k = 0;
        @(negedge clk);
        while (busy && k < LIMIT) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("idle_bound", 32'(busy), 32'd0);
    endtask

    task automatic wait_tx_empty();
        int n;
        n = 0;
        while (exp_tx.size() != 0 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (exp_tx.size() != 0) check("tx_bound", 32'(exp_tx.size()), 32'd0);
    endtask

    // Serial decoder for uart_tx; a reset mid-byte abandons the partial byte.
    initial begin : tx_mon
        logic prev, aborted;
        logic [8:0] bits;
        logic [7:0] e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && prev && !uart_tx) begin
                aborted = 1'b0;
                repeat (CPB / 2) begin
                    @(negedge clk);
                    if (rst) aborted = 1'b1;
                end
                for (int i = 0; i < 9; i++) begin
                    if (!aborted) begin
                        repeat (CPB) begin
                            @(negedge clk);
                            if (rst) aborted = 1'b1;
                        end
                        bits[i] = uart_tx;
                    end
                end
                if (!aborted) begin
                    check("tx_stop", 32'(bits[8]), 32'd1);
                    if (exp_tx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected: got %0h expected none", bits[7:0]);
                    end else begin
                        e = exp_tx.pop_front();
                        check("tx_byte", 32'(bits[7:0]), 32'(e));
                    end
                end
            end
            prev = uart_tx;
        end
    end

    initial begin : rsp_mon
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!rst && timeout && !rsp_valid) check("timeout_alone", 32'(timeout), 32'd0);
            if (!rst && rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got %0h expected none", rsp_data);
                end else begin
                    e = exp_rsp.pop_front();
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                    check("rsp_timeout", 32'(timeout), 32'(e.to));
                    check("rsp_busy", 32'(busy), 32'd0);
                end
            end
        end
    end

    initial begin : main
        int k;
        rsp_t r;
        rst = 1'b1;
        req_valid = 1'b0;
        req_data = '0;
        uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Write: A1 2A BC 5A, no response
        push_frame({1'b1, 2'b00, 14'h2ABC, 8'h5A});
        pulse_req({1'b1, 2'b00, 14'h2ABC, 8'h5A});
        wait_idle(k);
        check("write_latency", 32'(k), 32'd162);
        @(posedge clk); #1;
        check("write_tx_left", 32'(exp_tx.size()), 32'd0);

        // Read answered with C3
        push_frame({1'b0, 2'b00, 14'h0123, 8'h00});
        r.data = 8'hC3; r.to = 1'b0; exp_rsp.push_back(r);
        pulse_req({1'b0, 2'b00, 14'h0123, 8'h00});
        wait_tx_empty();
        @(posedge clk); #1;
        send_rx(8'hC3, 1'b1);
        wait_idle(k);
        check("read_rsp_left", 32'(exp_rsp.size()), 32'd0);

        // Read with no answer: FF after 16 bit-times
        push_frame({1'b0, 2'b00, 14'h1555, 8'h00});
        r.data = 8'hFF; r.to = 1'b1; exp_rsp.push_back(r);
        pulse_req({1'b0, 2'b00, 14'h1555, 8'h00});
        k = 0;
        @(negedge clk);
        while (!rsp_valid && k < LIMIT) begin
            @(negedge clk);
            k++;
        end
        check("timeout_latency", 32'(k), 32'd226);
        @(posedge clk); #1;
        check("timeout_rsp_left", 32'(exp_rsp.size()), 32'd0);

        // Second request edge during TX
        push_frame({1'b1, 2'b00, 14'h0F0F, 8'hE7});
        pulse_req({1'b1, 2'b00, 14'h0F0F, 8'hE7});
        repeat (30) @(posedge clk);
        #1;
        req_data = 25'h1FFFFFF;
        req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("overrun_set", 32'(overrun), 32'd1);
        wait_idle(k);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Stray byte while idle
        @(posedge clk); #1;
        send_rx(8'h77, 1'b1);
        repeat (10) @(negedge clk);
        check("stray_frame_err", 32'(frame_err), 32'd0);
        check("stray_busy", 32'(busy), 32'd0);

        // Bad stop bit lands in AWAIT_RSP, then a good 96
        push_frame({1'b0, 2'b00, 14'h2000, 8'h00});
        r.data = 8'h96; r.to = 1'b0; exp_rsp.push_back(r);
        pulse_req({1'b0, 2'b00, 14'h2000, 8'h00});
        repeat (127) @(posedge clk);
        #1;
        send_rx(8'h3C, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        send_rx(8'h96, 1'b1);
        wait_idle(k);
        check("frame_err_set", 32'(frame_err), 32'd1);
        check("frame_err_rsp_left", 32'(exp_rsp.size()), 32'd0);

        // One-cycle low glitch during AWAIT_RSP must not swallow the real byte
        push_frame({1'b0, 2'b00, 14'h0456, 8'h00});
        r.data = 8'hA5; r.to = 1'b0; exp_rsp.push_back(r);
        pulse_req({1'b0, 2'b00, 14'h0456, 8'h00});
        wait_tx_empty();
        repeat (4) @(posedge clk);
        #1;
        uart_rx = 1'b0;
        @(posedge clk); #1;
        uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send_rx(8'hA5, 1'b1);
        wait_idle(k);
        check("glitch_rsp_left", 32'(exp_rsp.size()), 32'd0);

        // Reset during byte1 bit 4, then a clean frame
        push_frame({1'b1, 2'b00, 14'h1234, 8'h56});
        pulse_req({1'b1, 2'b00, 14'h1234, 8'h56});
        repeat (59) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_uart_tx", 32'(uart_tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_overrun", 32'(overrun), 32'd0);
        check("abort_frame_err", 32'(frame_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_tx.delete();
        push_frame({1'b1, 2'b00, 14'h1234, 8'h56});
        pulse_req({1'b1, 2'b00, 14'h1234, 8'h56});
        wait_idle(k);
        check("after_reset_latency", 32'(k), 32'd162);
        repeat (5) @(negedge clk);
        check("final_tx_left", 32'(exp_tx.size()), 32'd0);
        check("final_rsp_left", 32'(exp_rsp.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/bridge_uart_link.md
Name: bridge_uart_link

Overview:
- Sits directly downstream of slave_bus_bridge and converts its parallel request/response registers into a UART link to the remote bus segment.
- Takes the 25-bit request word {mode, 2'b00, addr[13:0], wdata[7:0]} and sends it as a fixed 4-byte 8N1 frame.
- For reads (mode=0), waits for one response byte from the remote side and returns it to the bridge.
- Reports overrun, framing-error and timeout conditions.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (≥4); 434 = 50 MHz / 115200.
- RSP_TIMEOUT_BITS, 64, bit-times to wait for a read response before giving up.
- TIMEOUT_DATA, 8'hFF, byte returned on timeout.

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  reset; synchronous, active-high.
- req_data  in  25  request word; connects to bridge uart_register_out.
- req_valid  in  1  request strobe; connects to bridge valid_out.
- rsp_data  out  8  read data; connects to bridge uart_register_in.
- rsp_valid  out  1  one-cycle response strobe; connects to bridge valid_in.
- uart_tx  out  1  serial out, idles high.
- uart_rx  in  1  serial in, asynchronous.
- busy  out  1  high whenever FSM is not IDLE.
- overrun  out  1  sticky: req_valid rising edge seen while busy.
- frame_err  out  1  sticky: RX byte with stop bit = 0.
- timeout  out  1  one-cycle pulse when response wait expires.

Behaviour:

Reset values:
- uart_tx=1; rsp_data=0; rsp_valid=0; busy=0; overrun=0; frame_err=0; timeout=0.
- All counters 0; FSM in IDLE; RX core idle.
- rst asserted mid-frame aborts immediately: uart_tx returns high on the next edge and any partial byte is discarded.
- Sticky flags clear only on rst.

Request capture:
- Acts on the rising edge of req_valid (registered previous value); level-high is not re-captured.
- In IDLE, the edge latches req_data into req_q and the FSM goes to TX_LOAD.
- An edge while not IDLE is dropped and sets overrun.

TX frame (byte order, MSB byte first):
- byte0 = {4'hA, 3'b000, req_q[24]}
- byte1 = req_q[23:16], byte2 = req_q[15:8], byte3 = req_q[7:0]
- Each byte is 8N1, LSB first: start 0, d0..d7, stop 1; every bit held exactly CLKS_PER_BIT cycles.
- Bytes go back-to-back with no idle gap.

FSM states:
- IDLE → TX_LOAD (on capture).
- TX_LOAD: load 10-bit shifter with {1, byte[k], 0}; bit counter = 0 → TX_SHIFT.
- TX_SHIFT: baud counter counts 0..CLKS_PER_BIT-1; on wrap, shift and increment the bit counter. After bit 9:
  - k<3: k++ → TX_LOAD.
  - k==3 and mode=1 → IDLE.
  - k==3 and mode=0 → AWAIT_RSP.
- uart_tx is registered: the start bit appears one cycle after TX_LOAD.
- AWAIT_RSP: timeout counter increments once per bit-time.
  - Valid RX byte arrives → rsp_data=byte, rsp_valid=1 for one cycle → IDLE.
  - Counter reaches RSP_TIMEOUT_BITS first → rsp_data=TIMEOUT_DATA, rsp_valid=1, timeout=1 (same cycle) → IDLE.
  - If byte completion and expiry fall in the same cycle, the byte wins.
- rsp_data holds its value until the next response.

RX path:
- uart_rx passes through a 2-flop synchronizer.
- Start is detected on a synchronized falling edge while the RX core is idle; re-checked low at CLKS_PER_BIT/2. A high sample there is a glitch: return to idle with no flag.
- Data bits are sampled at mid-bit, every CLKS_PER_BIT thereafter.
- Stop bit: if 0, set frame_err and discard the byte. In AWAIT_RSP the FSM keeps waiting.
- The RX core runs in every state, but bytes completed outside AWAIT_RSP are discarded silently (stray bytes).
- rsp_valid is never asserted outside a read.

Width rules:
- Baud counter is $clog2(CLKS_PER_BIT) bits; timeout counter is $clog2(RSP_TIMEOUT_BITS+1) bits.
- Byte index is 2 bits; TX bit counter is 4 bits.

Latency:
- Write: req_valid edge to uart_tx idle is 2 + 40·CLKS_PER_BIT cycles.

Decomposition:
- Package bridge_link_pkg:
  - state enum {IDLE, TX_LOAD, TX_SHIFT, AWAIT_RSP};
  - REQ_W=25, FRAME_BYTES=4, HDR_NIBBLE=4'hA;
  - a function frame_byte(req, k) returning byte k of the frame.
- Sub-module uart_rx_core (CLKS_PER_BIT): synchronizer, start qualification, sampling. Outputs byte[7:0], byte_valid (one-cycle), frame_err_pulse.
- The TX path stays inline in the top module.

Test Plan (CLKS_PER_BIT=4, RSP_TIMEOUT_BITS=16):
- Write: req_data={1,2'b00,14'h2ABC,8'h5A}, pulse req_valid → uart_tx decodes bytes A1,2A,BC,5A with 4 cycles/bit; no rsp_valid; busy low after 162 cycles.
- Read: req_data={0,2'b00,14'h0123,8'h00} → bytes A0,01,23,00; the bench then drives RX byte 8'hC3 → rsp_valid one cycle with rsp_data=C3; then IDLE.
- Timeout: read request with no RX activity → after 16 bit-times rsp_valid=1, rsp_data=FF, timeout pulse; busy falls the same cycle.
- Overrun and stray bytes:
  - second req_valid edge during TX → frame unchanged, overrun=1 and stays set;
  - RX byte 8'h77 sent while IDLE → no rsp_valid.
- Framing error and glitch:
  - during AWAIT_RSP, send 8'h3C with stop=0 → frame_err=1, no rsp_valid; a following good 8'h96 → rsp_data=96;
  - a 1-cycle low glitch on uart_rx → ignored.
- Reset mid-byte: assert rst during byte1 bit 4 → uart_tx=1 next cycle, busy=0; a new request afterwards sends a clean full frame.
